// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, keyboard command bytes and
// frame constants used by the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_LED    = 8'hED;
  localparam logic [7:0] CMD_ECHO   = 8'hEE;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] ACK_BYTE   = 8'hFA;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BIT_IDX_W  = 4;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 host transmitter.
//   tx_data/tx_valid : command byte offered by the controller
//   tx_ready         : transmitter idle and able to accept
//   done/err         : one-cycle completion / failure pulses
//   busy/rx_inhibit  : transfer in progress (rx_inhibit gates the receiver)
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       err;
  logic       busy;
  logic       rx_inhibit;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, done, err, busy, rx_inhibit
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, done, err, busy, rx_inhibit
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one raw PS/2 line.
//   clk, rst : system clock, async active-high reset
//   din      : raw asynchronous pin
//   sync     : synchronized level (resets to the idle-high bus level)
//   fe_c     : combinational falling-edge strobe, one cycle wide
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fe_c
);
  logic meta_q;
  logic cur_q;
  logic prev_q;

  // Reset to 1 so a released bus does not look like an edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      cur_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      cur_q  <= meta_q;
      prev_q <= cur_q;
    end
  end

  assign sync = cur_q;
  assign fe_c = prev_q & ~cur_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain via output enables).
//   clk, rst            : system clock, async active-high reset
//   bus (slave)         : tx_data/tx_valid in; tx_ready/done/err/busy/rx_inhibit out
//   ps2_clk_in/data_in  : raw asynchronous bus pins
//   ps2_clk_oe/data_oe  : 1 = pull the line low
// Optional: define PS2_HOST_TX_RETRY_EN to retry a failed frame up to twice.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned SETUP_CYCLES   = 100,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CNT_W          = 21
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam logic [CNT_W-1:0]     INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] STOP_IDX     = BIT_IDX_W'(FRAME_BITS - 2);
  localparam logic [BIT_IDX_W-1:0] PARITY_IDX   = BIT_IDX_W'(FRAME_BITS - 3);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           byte_q, byte_d;
  logic                 parity_q, parity_d;
  logic                 data_oe_q, data_d;
  logic                 clk_oe_q, tx_ready_q, busy_q, done_q, err_q;
  logic                 done_d, err_d, fail, timeout;
  logic                 clk_sync, clk_fe_c, data_sync, data_fe_unused;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]           retry_q, retry_d;
`endif

  ps2_line_sync u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_clk_in),
    .sync (clk_sync),
    .fe_c (clk_fe_c)
  );

  ps2_line_sync u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_data_in),
    .sync (data_sync),
    .fe_c (data_fe_unused)
  );

  // Next-state, counter and line-drive decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    data_d    = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail      = 1'b0;
    timeout   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        data_d = 1'b0;
        if (bus.tx_valid) begin
          byte_d   = bus.tx_data;
          parity_d = odd_parity(bus.tx_data);
          cnt_d    = '0;
          state_d  = ST_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_d  = 2'd0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d   = '0;
          data_d  = 1'b1;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clk_fe_c) begin
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q < PARITY_IDX) begin
            data_d = ~byte_q[bit_idx_q[2:0]];
          end else if (bit_idx_q == PARITY_IDX) begin
            data_d = ~parity_q;
          end else if (bit_idx_q == STOP_IDX) begin
            data_d  = 1'b0;
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clk_fe_c) begin
          if (!data_sync) state_d = ST_WAIT_IDLE;
          else            fail    = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout wins over a completion landing in the same cycle.
    if ((state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) &&
        (cnt_q == TIMEOUT_LAST)) begin
      timeout = 1'b1;
    end

    if (fail || timeout) begin
      done_d    = 1'b0;
      data_d    = 1'b0;
      cnt_d     = '0;
      bit_idx_d = '0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d = retry_q + 2'd1;
        state_d = ST_INHIBIT;
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
`else
      err_d   = 1'b1;
      state_d = ST_IDLE;
`endif
    end
  end

  // State and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      clk_oe_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      data_oe_q  <= data_d;
      clk_oe_q   <= (state_d == ST_INHIBIT) || (state_d == ST_REQ);
      tx_ready_q <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef PS2_HOST_TX_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retry_q <= 2'd0;
    else     retry_q <= retry_d;
  end
`endif

  assign bus.tx_ready   = tx_ready_q;
  assign bus.busy       = busy_q;
  assign bus.rx_inhibit = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_data_oe    = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with a behavioural PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int SET  = 10;
  localparam int TO   = 1000;
  localparam int HALF = 20;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low;
  logic dev_data_low;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_in, ps2_data_in;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (21)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // Open-drain wired-AND with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int oe_run = 0, last_oe_run = 0, rel_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.err) begin err_cnt++; err_cyc = cyc; end
    if (bus.done && bus.err) both_cnt++;
    if (ps2_clk_oe) oe_run++;
    else if (oe_run != 0) begin last_oe_run = oe_run; oe_run = 0; rel_cyc = cyc; end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int k;
    bit seen;
    k = 0;
    while (!ps2_clk_oe && k < 100) begin @(negedge clk); k++; end
    seen = ps2_clk_oe;
    k = 0;
    while (ps2_clk_oe && k < INH + SET + 100) begin @(negedge clk); k++; end
    ok = seen && !ps2_clk_oe;
  endtask

  task automatic dev_pulse(output logic s);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    s = ps2_data_in;
    dev_clk_low = 1'b0;
  endtask

  // One host-to-device frame: fr = {stop, parity, data[7:0], start}.
  task automatic dev_frame(input bit ack, output logic [10:0] fr, output bit ok);
    logic s;
    fr = '0;
    wait_release(ok);
    if (!ok) return;
    fr[0] = ps2_data_in;
    for (int i = 1; i <= 10; i++) begin
      dev_pulse(s);
      fr[i] = s;
    end
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = ack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    while (!bus.tx_ready && k < ATTEMPTS * (INH + SET + TO) + 500) begin
      @(negedge clk); k++;
    end
    ok = bus.tx_ready;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 1", bus.tx_ready); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.rx_inhibit !== 1'b0) begin n_fail++; $display("FAIL rst_rx_inhibit: got %b want 0", bus.rx_inhibit); end
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_ed();
    localparam logic [10:0] EXP = {1'b1, 1'b1, 8'hED, 1'b0};
    int d0, e0;
    logic [10:0] fr;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_LED);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ed_busy_during: got %b want 1", bus.busy); end
    n_checks++; if (bus.rx_inhibit !== 1'b1) begin n_fail++; $display("FAIL ed_rx_inhibit_during: got %b want 1", bus.rx_inhibit); end
    dev_frame(1'b1, fr, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ed_release: got %b want 1", ok); end
    n_checks++; if (fr !== EXP) begin n_fail++; $display("FAIL ed_frame: got %b want %b", fr, EXP); end
    n_checks++; if (last_oe_run !== INH + SET) begin n_fail++; $display("FAIL ed_clk_oe_len: got %0d want %0d", last_oe_run, INH + SET); end
    wait_ready(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ed_ready_timeout: got %b want 1", ok); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ed_done_count: got %0d want 1", done_cnt - d0); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL ed_err_count: got %0d want 0", err_cnt - e0); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ed_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_parity_f4();
    int d0;
    logic [10:0] fr;
    bit ok;
    d0 = done_cnt;
    send(CMD_ENABLE);
    dev_frame(1'b1, fr, ok);
    n_checks++; if (fr[9] !== 1'b0) begin n_fail++; $display("FAIL f4_parity: got %b want 0", fr[9]); end
    n_checks++; if (fr[8:1] !== 8'hF4) begin n_fail++; $display("FAIL f4_data: got %h want f4", fr[8:1]); end
    wait_ready(ok);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL f4_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_nack();
    localparam logic [10:0] EXP = {1'b1, 1'b1, 8'h00, 1'b0};
    int d0, e0;
    logic [10:0] fr;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(1'b0, fr, ok);
      n_checks++; if (fr !== EXP) begin n_fail++; $display("FAIL nack_frame%0d: got %b want %b", a, fr, EXP); end
      if (a < ATTEMPTS - 1) begin
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL nack_early_err%0d: got %0d want 0", a, err_cnt - e0); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL nack_busy_retry%0d: got %b want 1", a, bus.busy); end
      end
    end
    wait_ready(ok);
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL nack_err_cycles: got %0d want 1", err_cnt - e0); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL nack_done: got %0d want 0", done_cnt - d0); end
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
  endtask

  task automatic test_timeout();
    int d0, e0;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_RESET);
    wait_ready(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_ready_timeout: got %b want 1", ok); end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL to_err_count: got %0d want 1", err_cnt - e0); end
    n_checks++; if (err_cyc - rel_cyc !== TO) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", err_cyc - rel_cyc, TO); end
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL to_data_oe: got %b want 0", ps2_data_oe); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL to_done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe();
    localparam logic [10:0] EXP = {1'b1, 1'b1, 8'hEE, 1'b0};
    logic [10:0] fr;
    logic s;
    bit ok;
    int d0;
    // Reset while the start bit is being driven.
    send(CMD_RESET);
    repeat (INH + 3) @(negedge clk);
    n_checks++; if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL req_data_oe: got %b want 1", ps2_data_oe); end
    rst = 1'b1;
    #1;
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL req_rst_clk_oe: got %b want 0", ps2_clk_oe); end
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL req_rst_data_oe: got %b want 0", ps2_data_oe); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // Reset during data bit 4.
    send(CMD_RESET);
    wait_release(ok);
    for (int i = 0; i < 5; i++) dev_pulse(s);
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_clk_oe: got %b want 0", ps2_clk_oe); end
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_data_oe: got %b want 0", ps2_data_oe); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    send(CMD_ECHO);
    dev_frame(1'b1, fr, ok);
    n_checks++; if (fr !== EXP) begin n_fail++; $display("FAIL ee_frame: got %b want %b", fr, EXP); end
    wait_ready(ok);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ee_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    localparam logic [10:0] EXP1 = {1'b1, 1'b1, 8'hED, 1'b0};
    localparam logic [10:0] EXP2 = {1'b1, 1'b1, 8'h55, 1'b0};
    logic [10:0] fr1, fr2;
    bit ok;
    int d0, k;
    d0 = done_cnt;
    send(CMD_LED);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    dev_frame(1'b1, fr1, ok);
    k = 0;
    while (!ps2_clk_oe && k < 100) begin @(negedge clk); k++; end
    n_checks++; if (ps2_clk_oe !== 1'b1) begin n_fail++; $display("FAIL b2b_second_start: got %b want 1", ps2_clk_oe); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL b2b_done_before_second: got %0d want 1", done_cnt - d0); end
    bus.tx_valid = 1'b0;
    dev_frame(1'b1, fr2, ok);
    wait_ready(ok);
    n_checks++; if (fr1 !== EXP1) begin n_fail++; $display("FAIL b2b_frame1: got %b want %b", fr1, EXP1); end
    n_checks++; if (fr2 !== EXP2) begin n_fail++; $display("FAIL b2b_frame2: got %b want %b", fr2, EXP2); end
    n_checks++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    repeat (INH) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third: got %b want 0", bus.busy); end
  endtask

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset();
    test_send_ed();
    test_parity_f4();
    test_nack();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends single command bytes to the keyboard, such as LED set 0xED, reset 0xFF and enable 0xF4, over the same ps2_clk/ps2_data pair the keyboard receiver listens on. Lines are driven open-drain through output-enable signals; the top level builds the tristate buffers. While a transmission is in progress it asserts rx_inhibit so the receiver ignores bus activity.

Parameters:
INHIBIT_CYCLES, 12000, clk cycles ps2_clk is held low before the request (120 us at 100 MHz)
SETUP_CYCLES, 100, clk cycles ps2_data is held low with ps2_clk still low, before ps2_clk is released
TIMEOUT_CYCLES, 2000000, maximum clk cycles from ps2_clk release to ACK (20 ms)
CNT_W, 21, width of the shared cycle counter; must hold the largest cycle parameter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_data  in  8  command byte
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high only in IDLE
done  out  1  one-cycle pulse: byte sent and ACK received
err  out  1  one-cycle pulse: timeout or missing ACK
busy  out  1  high in any state other than IDLE
rx_inhibit  out  1  equals busy
ps2_clk_in  in  1  raw ps2_clk pin (asynchronous)
ps2_data_in  in  1  raw ps2_data pin (asynchronous)
ps2_clk_oe  out  1  1 = drive ps2_clk low
ps2_data_oe  out  1  1 = drive ps2_data low

Behaviour:
- Reset (async): state IDLE, all counters 0. Outputs: tx_ready=1, done=0, err=0, busy=0, rx_inhibit=0, ps2_clk_oe=0, ps2_data_oe=0. Both lines are released immediately, including mid-frame.
- Input conditioning: both inputs pass a 2-flop synchronizer. A falling edge (fe) is sync_prev=1 & sync_cur=0. An edge is seen 2-3 clk after the pin changes.
- Accept: on tx_valid & tx_ready, latch tx_data into shift_reg and compute parity = ~^tx_data (odd parity). Move to INHIBIT on the next cycle. tx_valid while busy is ignored. The host has priority and starts even if the device is mid-send.
- IDLE: no lines driven.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES, then go to REQ.
- REQ: clk_oe=1 and data_oe=1 (start bit) for SETUP_CYCLES, then go to SHIFT. Clear the counter and bit index.
- SHIFT: clk_oe=0; data_oe holds the current bit value. On fe number k (k=1..10):
  - k=1..8: data_oe = ~shift_reg[k-1], LSB first.
  - k=9: data_oe = ~parity.
  - k=10: data_oe=0 (stop bit released); then go to ACK.
  - fe during INHIBIT or REQ is ignored.
- ACK: on the next fe, sample sync data. If 0, go to WAIT_IDLE. If 1, pulse err and go to IDLE.
- WAIT_IDLE: when sync clk=1 and sync data=1, pulse done and go to IDLE.
- Timeout: the counter runs from REQ exit through SHIFT, ACK and WAIT_IDLE. If it reaches TIMEOUT_CYCLES, release lines, pulse err and go to IDLE. An expiry coinciding with the completing event gives priority to the timeout (err).
- done and err are never asserted in the same cycle.
- Latency: at least INHIBIT_CYCLES+SETUP_CYCLES+1 cycles from accept to ps2_clk release.

Optional Feature:
- Macro PS2_HOST_TX_RETRY_EN.
- Defined: on an error (timeout or NACK), the block restarts from INHIBIT with the same latched byte, up to 2 retries. err pulses only after the third failure. busy stays high across retries.
- Undefined: the first failure pulses err and returns to IDLE. Retry counter logic is absent.

Decomposition:
- Package ps2_pkg:
  - state encoding localparams (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE)
  - PS/2 command constants: CMD_LED=8'hED, CMD_ECHO=8'hEE, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF
  - ACK byte 8'hFA, frame bit count 11
- One sub-module, ps2_line_sync: 2-flop synchronizer plus falling-edge detect. It is also instantiated by the keyboard receiver.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs. Expect:
  - ps2_clk_oe high for exactly 12000+100 cycles
  - data bits 1,0,1,1,0,1,1,1, parity 1, stop released
  - done pulses once; tx_ready returns to 1.
- Send 0xF4 -> parity bit 0 observed on the 9th fe; done=1.
- Send 0x00, device leaves data high at the ACK fe -> err pulses 1 cycle, done stays 0. With PS2_HOST_TX_RETRY_EN: 3 complete frames before err.
- Send 0xFF, device never clocks -> err exactly TIMEOUT_CYCLES after ps2_clk release; ps2_data_oe=0 afterwards.
- Assert rst during bit 4 of 0xFF -> same cycle: ps2_clk_oe=0, ps2_data_oe=0, busy=0. A new 0xEE then sends cleanly.
- Hold tx_valid with 0x55 during a busy 0xED send -> 0x55 is accepted only after done; exactly two frames appear on the bus, in order.
